// File: rtl/mask_bbox_stats_if.sv
// Bundle between the mask stream source and mask_bbox_stats: pixel/sync inputs
// plus the per-frame statistics that come back.
interface mask_bbox_stats_if;
  // Stream contract: ce qualifies every input; in_de high on a ce cycle is a
  // valid pixel that is always taken (no ready, one pixel per enabled clock);
  // frame_valid is a one-clock pulse marking new values on the stat outputs.
  logic        ce;
  logic        mask;
  logic        in_de;
  logic        in_hsync;
  logic        in_vsync;
  logic [9:0]  bb_x_min;
  logic [9:0]  bb_x_max;
  logic [9:0]  bb_y_min;
  logic [9:0]  bb_y_max;
  logic [19:0] pix_count;
  logic        found;
  logic        frame_valid;

  modport master (
    output ce, mask, in_de, in_hsync, in_vsync,
    input  bb_x_min, bb_x_max, bb_y_min, bb_y_max, pix_count, found, frame_valid
  );

  modport slave (
    input  ce, mask, in_de, in_hsync, in_vsync,
    output bb_x_min, bb_x_max, bb_y_min, bb_y_max, pix_count, found, frame_valid
  );
endinterface

// File: rtl/mask_bbox_stats.sv
// Per-frame bounding box and set-pixel population of a binary mask stream,
// reported one frame late on each vsync rising edge.
module mask_bbox_stats #(
  parameter logic [9:0]  H_SIZE     = 10'd83,
  parameter logic [19:0] MIN_PIXELS = 20'd16
) (
  input  logic             clk,
  input  logic             rst,
  mask_bbox_stats_if.slave bus,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        de_prev_q, de_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [19:0] cnt_q, cnt_d;
  logic [9:0]  xmin_q, xmin_d, xmax_q, xmax_d;
  logic [9:0]  ymin_q, ymin_d, ymax_q, ymax_d;
  logic [9:0]  ox_min_q, ox_min_d, ox_max_q, ox_max_d;
  logic [9:0]  oy_min_q, oy_min_d, oy_max_q, oy_max_d;
  logic [19:0] opix_q, opix_d;
  logic        found_q, found_d;
  logic        fv_q, fv_d;

  logic        vs_rise;
  logic        de_fall;
  logic        pix_ok;
  logic        unused_hsync;

  assign unused_hsync = bus.in_hsync;

  always_comb begin
    vs_rise = bus.ce & bus.in_vsync & ~vs_prev_q;
    de_fall = bus.ce & ~bus.in_de & de_prev_q;
    // A pixel coinciding with the vsync rise belongs to neither frame.
    pix_ok  = bus.ce && (state_q == S_ACCUM) && bus.in_de && bus.mask &&
              (x_q < H_SIZE) && !vs_rise;
  end

  always_comb begin
    state_d   = state_q;
    de_prev_d = de_prev_q;
    vs_prev_d = vs_prev_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    xmin_d    = xmin_q;
    xmax_d    = xmax_q;
    ymin_d    = ymin_q;
    ymax_d    = ymax_q;
    ox_min_d  = ox_min_q;
    ox_max_d  = ox_max_q;
    oy_min_d  = oy_min_q;
    oy_max_d  = oy_max_q;
    opix_d    = opix_q;
    found_d   = found_q;
    fv_d      = 1'b0;

    if (bus.ce) begin
      de_prev_d = bus.in_de;
      vs_prev_d = bus.in_vsync;

      if (!bus.in_de)          x_d = '0;
      else if (x_q < H_SIZE)   x_d = x_q + 10'd1;

      if (vs_rise)                      y_d = '0;
      else if (de_fall && y_q != 10'h3FF) y_d = y_q + 10'd1;

      if (pix_ok) begin
        if (cnt_q != 20'hF_FFFF) cnt_d = cnt_q + 20'd1;
        if (cnt_q == '0) begin
          xmin_d = x_q;
          xmax_d = x_q;
          ymin_d = y_q;
          ymax_d = y_q;
        end else begin
          if (x_q < xmin_q) xmin_d = x_q;
          if (x_q > xmax_q) xmax_d = x_q;
          if (y_q < ymin_q) ymin_d = y_q;
          if (y_q > ymax_q) ymax_d = y_q;
        end
      end

      case (state_q)
        S_IDLE:  if (vs_rise) state_d = S_ACCUM;
        S_ACCUM: if (vs_rise) state_d = S_REPORT;
        S_REPORT: begin
          ox_min_d = (cnt_q == '0) ? 10'd0 : xmin_q;
          ox_max_d = (cnt_q == '0) ? 10'd0 : xmax_q;
          oy_min_d = (cnt_q == '0) ? 10'd0 : ymin_q;
          oy_max_d = (cnt_q == '0) ? 10'd0 : ymax_q;
          opix_d   = cnt_q;
          found_d  = (cnt_q >= MIN_PIXELS);
          fv_d     = 1'b1;
          cnt_d    = '0;
          xmin_d   = '0;
          xmax_d   = '0;
          ymin_d   = '0;
          ymax_d   = '0;
          state_d  = S_ACCUM;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymin_q    <= '0;
      ymax_q    <= '0;
      ox_min_q  <= '0;
      ox_max_q  <= '0;
      oy_min_q  <= '0;
      oy_max_q  <= '0;
      opix_q    <= '0;
      found_q   <= 1'b0;
      fv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      de_prev_q <= de_prev_d;
      vs_prev_q <= vs_prev_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymin_q    <= ymin_d;
      ymax_q    <= ymax_d;
      ox_min_q  <= ox_min_d;
      ox_max_q  <= ox_max_d;
      oy_min_q  <= oy_min_d;
      oy_max_q  <= oy_max_d;
      opix_q    <= opix_d;
      found_q   <= found_d;
      fv_q      <= fv_d;
    end
  end

  assign bus.bb_x_min    = ox_min_q;
  assign bus.bb_x_max    = ox_max_q;
  assign bus.bb_y_min    = oy_min_q;
  assign bus.bb_y_max    = oy_max_q;
  assign bus.pix_count   = opix_q;
  assign bus.found       = found_q;
  assign bus.frame_valid = fv_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_mask_bbox_stats.sv
// Directed frames against a frame-level model of the bbox/count rules, with
// literal expectations for the headline cases.
module tb_mask_bbox_stats;
  localparam int HS = 83;
  localparam int W  = 61;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  mask_bbox_stats_if bus ();

  mask_bbox_stats dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  last_exp;
  logic [W-1:0]  got;
  bit            fv_prev;
  bit            stall;

  // ---------------- model ----------------
  function automatic bit mask_fn(input int kind, input int x, input int y);
    case (kind)
      1:       return (x == 10 && y == 5);
      2:       return (x >= 20 && x <= 39 && y >= 8 && y <= 17);
      3:       return (x >= 83);
      4:       return (((x * 3 + y * 7) % 11) == 0) && x >= 4 && y >= 2;
      5:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] pack(input int a, input int b, input int c,
                                        input int d, input int n, input bit f);
    return {10'(a), 10'(b), 10'(c), 10'(d), 20'(n), f};
  endfunction

  // Rows seen by the block are the line index plus y_off.
  function automatic logic [W-1:0] model(input int kind, input int lines,
                                         input int width, input int y_off);
    int cnt, xmn, xmx, ymn, ymx, r;
    cnt = 0; xmn = 0; xmx = 0; ymn = 0; ymx = 0;
    for (int y = 0; y < lines; y++)
      for (int x = 0; x < width; x++)
        if (mask_fn(kind, x, y) && x < HS) begin
          r = y + y_off;
          if (cnt == 0) begin
            xmn = x; xmx = x; ymn = r; ymx = r;
          end else begin
            if (x < xmn) xmn = x;
            if (x > xmx) xmx = x;
            if (r < ymn) ymn = r;
            if (r > ymx) ymx = r;
          end
          cnt++;
        end
    return pack(xmn, xmx, ymn, ymx, cnt, cnt >= 16);
  endfunction

  function automatic logic [W-1:0] got_now();
    return {bus.bb_x_min, bus.bb_x_max, bus.bb_y_min, bus.bb_y_max,
            bus.pix_count, bus.found};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    got = got_now();
    if (bus.frame_valid) begin
      check("fv_not_consecutive", W'(fv_prev), '0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame_valid: got report %h expected none at %0t",
                 got, $time);
      end else begin
        last_exp = exp_q.pop_front();
        check("report", got, last_exp);
      end
    end else begin
      check("hold", got, last_exp);
    end
    fv_prev = bus.frame_valid;
  end

  // ---------------- drivers ----------------
  task automatic tick(input bit c);
    bus.ce = c;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int stalls);
    for (int i = 0; i < stalls; i++) tick(1'b0);
    tick(1'b1);
  endtask

  function automatic int nst();
    return stall ? 1 : 0;
  endfunction

  task automatic drive_frame(input int kind, input int lines, input int width);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < width; x++) begin
        bus.in_de = 1'b1;
        bus.mask  = mask_fn(kind, x, y);
        cyc(nst());
      end
      bus.in_de = 1'b0;
      bus.mask  = 1'b0;
      for (int b = 0; b < 4; b++) begin
        bus.in_hsync = (b == 1);
        cyc(nst());
      end
    end
  endtask

  // In stall mode ce stays low for several clocks across the raw vsync rise.
  task automatic drive_vsync(input bit edge_pixel, input bit push,
                             input logic [W-1:0] e);
    if (push) exp_q.push_back(e);
    bus.in_vsync = 1'b1;
    bus.in_de    = edge_pixel;
    bus.mask     = edge_pixel;
    cyc(stall ? 3 : 0);
    bus.in_de = 1'b0;
    bus.mask  = 1'b0;
    for (int i = 0; i < 3; i++) cyc(nst());
    bus.in_vsync = 1'b0;
    for (int i = 0; i < 3; i++) cyc(nst());
    if (push) check("report_seen", W'(exp_q.size()), '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    stall        = 1'b0;
    fv_prev      = 1'b0;
    last_exp     = '0;
    rst          = 1'b0;
    bus.ce       = 1'b0;
    bus.mask     = 1'b0;
    bus.in_de    = 1'b0;
    bus.in_hsync = 1'b0;
    bus.in_vsync = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", got_now(), '0);
    check("reset_fv", W'(bus.frame_valid), '0);
    check("reset_state_idle", W'(state_dbg), '0);

    // Partial frame of all-ones mask; reset released mid-line.
    for (int i = 0; i < 300; i++) begin
      bus.in_de = ((i % 87) < 83);
      bus.mask  = 1'b1;
      if (i == 130) rst = 1'b1;
      cyc(0);
    end
    drive_vsync(1'b0, 1'b0, '0);

    // Single pixel
    check("model_single", model(1, 12, 83, 0), pack(10, 10, 5, 5, 1, 1'b0));
    drive_frame(1, 12, 83);
    drive_vsync(1'b0, 1'b1, model(1, 12, 83, 0));
    check("single_literal", got_now(), pack(10, 10, 5, 5, 1, 1'b0));

    // Rectangle on an 83x64 frame
    check("model_rect", model(2, 64, 83, 0), pack(20, 39, 8, 17, 200, 1'b1));
    drive_frame(2, 64, 83);
    drive_vsync(1'b0, 1'b1, model(2, 64, 83, 0));
    check("rect_literal", got_now(), pack(20, 39, 8, 17, 200, 1'b1));

    // Empty frame
    drive_frame(0, 8, 83);
    drive_vsync(1'b0, 1'b1, model(0, 8, 83, 0));
    check("empty_literal", got_now(), '0);

    // Over-width lines, mask only beyond the active width
    check("model_overwidth", model(3, 8, 90, 0), '0);
    drive_frame(3, 8, 90);
    drive_vsync(1'b0, 1'b1, model(3, 8, 90, 0));
    check("overwidth_literal", got_now(), '0);

    // Scatter frame, ended by a vsync carrying a set pixel
    drive_frame(4, 20, 83);
    drive_vsync(1'b1, 1'b1, model(4, 20, 83, 0));

    // The edge pixel's de fall counts one line, so rows start at 1
    drive_frame(2, 64, 83);
    drive_vsync(1'b0, 1'b1, model(2, 64, 83, 1));
    check("rect_after_edge_literal", got_now(), pack(20, 39, 9, 18, 200, 1'b1));

    // Rectangle with ce toggling and held low across vsync
    stall = 1'b1;
    drive_frame(2, 64, 83);
    drive_vsync(1'b0, 1'b1, model(2, 64, 83, 0));
    stall = 1'b0;
    check("rect_stall_literal", got_now(), pack(20, 39, 8, 17, 200, 1'b1));

    // Asynchronous reset right after a report
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", got_now(), '0);
    check("async_reset_fv", W'(bus.frame_valid), '0);
    last_exp = '0;
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Back in IDLE: first vsync arms, second reports
    drive_vsync(1'b0, 1'b0, '0);
    drive_frame(4, 12, 83);
    drive_vsync(1'b0, 1'b1, model(4, 12, 83, 0));

    repeat (4) cyc(0);
    check("queue_drained", W'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mask_bbox_stats.md
# mask_bbox_stats

Per-frame bounding-box and pixel-count extractor for a binary mask stream. Sits directly downstream of `erosion3x3` in the skin-colour segmentation chain: consumes `eroded`, `out_de`, `out_hsync` and `out_vsync`. It produces, once per frame, the bounding rectangle and population of the set mask pixels for the tracking/overlay logic. Pure statistics stage; it does not forward video.

## Interface
- `H_SIZE`, 10'd83: active pixels per line; columns at or above `H_SIZE` are ignored.
- `MIN_PIXELS`, 20'd16: minimum set-pixel count for `found` to assert.
- `clk`  in  1  pixel clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable; when low, all state holds and inputs are ignored.
- `mask`  in  1  binary pixel; 1 means object.
- `in_de`  in  1  data enable; pixel valid when high.
- `in_hsync`  in  1  horizontal sync, pass-through timing only (unused internally).
- `in_vsync`  in  1  vertical sync, active high; rising edge marks frame boundary.
- `bb_x_min`, `bb_x_max`  out  10  column bounds of the last completed frame.
- `bb_y_min`, `bb_y_max`  out  10  row bounds of the last completed frame.
- `pix_count`  out  20  set-pixel count of the last completed frame, saturating.
- `found`  out  1  `pix_count >= MIN_PIXELS` for the last completed frame.
- `frame_valid`  out  1  one-cycle pulse when the outputs above update.

## Operation
- **Reset (`rst`=0):**
  - All outputs are 0.
  - FSM enters IDLE.
  - Counters and accumulators are cleared.
  - Sync edge registers are cleared.
- **Edge detection:** `in_de` and `in_vsync` are registered under `ce`. A rising or falling edge is (current & ~prev) or (~current & prev), evaluated only on `ce`=1 cycles.
- **Column counter `x` (10 bit):**
  - Cleared on every cycle with `in_de`=0.
  - Increments on each `in_de`=1 cycle.
  - Saturates at `H_SIZE`.
  - The pixel in that cycle has column = `x` before increment.
- **Row counter `y` (10 bit):**
  - Increments on each `in_de` falling edge.
  - Cleared on `in_vsync` rising edge.
  - Saturates at 1023.
- **FSM states:**
  - IDLE: waits for the first `in_vsync` rising edge, then goes to ACCUM without reporting. A partial frame after reset is discarded.
  - ACCUM: accumulates pixels. On an `in_vsync` rising edge it goes to REPORT.
  - REPORT: lasts one cycle. It latches the accumulators into the outputs, pulses `frame_valid`, clears the accumulators and returns to ACCUM.
- **Accumulation:** a pixel qualifies when all of the following hold in ACCUM: `ce`=1, `in_de`=1, `mask`=1, `x < H_SIZE`, and no `in_vsync` rising edge in the same cycle. For a qualifying pixel:
  - `cnt` = min(`cnt`+1, 2^20−1).
  - First qualifying pixel of the frame: all four bounds load `x`/`y`.
  - Later pixels: `xmin`=min, `xmax`=max, `ymin`=min, `ymax`=max.
- **Empty frame (`cnt`=0):** REPORT outputs all bounds as 0, `pix_count`=0, `found`=0. `frame_valid` still pulses.
- **Pixel on a vsync edge:** a pixel with `in_de`=1 in the same cycle as the `in_vsync` rising edge is discarded (belongs to neither frame).
- **`ce` low during REPORT:** the transition completes on the next `ce`=1 cycle; `frame_valid` is gated by `ce`.
- **Reset mid-frame:** immediate asynchronous clear, back to IDLE. The interrupted frame is never reported.

## Timing
- `in_vsync` rising edge sampled at cycle N (`ce`=1) moves the FSM to REPORT in cycle N+1.
- Outputs and `frame_valid`=1 appear registered at cycle N+2, relative to the edge-sampling register. Total latency from the raw `in_vsync` rise is 2 `ce` cycles.
- Outputs hold stable between `frame_valid` pulses.
- `frame_valid` is never high on two consecutive cycles.
- Pixel throughput is 1 per clock, with no back-pressure.

## Test plan
- **Single pixel:** frame 1 has `mask`=1 only at (x=10, y=5), then frame 2 starts. Expect `frame_valid` once, bounds 10/10/5/5, `pix_count`=1, `found`=0.
- **Rectangle:** 83×64 frame with mask set for x 20..39, y 8..17. Expect bounds 20/39/8/17, `pix_count`=200, `found`=1.
- **Post-reset discard:** release `rst` mid-frame with mask pixels present. Expect no `frame_valid` until the second vsync rise; that report covers only the full frame.
- **Empty and over-width frames:**
  - All-zero mask: expect all outputs 0 and `frame_valid` pulsed.
  - Lines of 90 pixels with mask=1 only at x≥83: expect `pix_count`=0.
- **`ce` stalls:** toggle `ce` 50% during the rectangle test and hold `ce`=0 across the vsync edge. Expect results identical to the rectangle test and `frame_valid` still a single `ce`-gated pulse.
- **Async reset after REPORT:** assert `rst` for 1 cycle right after a REPORT. Expect all outputs 0 immediately, without waiting for `clk`.
